// File: rtl/disparo_pkg.sv
// Shared types for the firing scheduler of the timed Petri net engine.
// FSM states, error codes and request-source encoding.
package disparo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    typedef enum logic {
        SRC_COLA = 1'b0,
        SRC_AUTO = 1'b1
    } src_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NO_SENS  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/cola_disparos.sv
// Request FIFO for bus-issued firings; show-ahead read of the oldest entry.
// Depth must be a power of two so the pointers wrap by overflow.
module cola_disparos #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/disparo_scheduler.sv
// Issues one firing at a time to the Petri net engine, alternating between
// queued bus requests and automatic transitions, and reports errors/interrupts.
module disparo_scheduler
    import disparo_pkg::*;
#(
    parameter int cant_transiciones      = 8,
    parameter int bits_cant_transiciones = 3,
    parameter int tamano_cola            = 4,
    parameter int timeout_ciclos         = 255
) (
    input  logic                              Bus2IP_Clk,
    input  logic                              Bus2IP_Reset,
    input  logic                              req_valid,
    input  logic [bits_cant_transiciones-1:0] req_trans,
    output logic                              req_ready,
    input  logic [cant_transiciones-1:0]      t_automatica,
    input  logic [cant_transiciones-1:0]      t_sensibilizadas,
    input  logic [cant_transiciones-1:0]      t_intr,
    output logic                              fire_start,
    output logic [bits_cant_transiciones-1:0] fire_trans,
    input  logic                              fire_done,
    input  logic                              fire_ok,
    output logic                              Interrupt,
    input  logic                              intr_clr,
    output logic [1:0]                        err_code,
    input  logic                              err_clr,
    output logic                              busy
);

    localparam int B  = bits_cant_transiciones;
    localparam int CW = $clog2(tamano_cola) + 1;
    localparam logic [CW-1:0] Q_FULL  = CW'(tamano_cola);
    localparam logic [7:0]    TIMEOUT = 8'(timeout_ciclos);

    state_t         state_q, state_d;
    src_t           last_src_q, last_src_d;
    logic [B-1:0]   fire_trans_q, fire_trans_d;
    logic           fire_start_q, fire_start_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           intr_q, intr_d;
    logic [1:0]     err_q, err_d;

    logic [B-1:0]   q_dout;
    logic           q_full, q_empty, q_pop;
    logic [CW-1:0]  q_count;

    logic [cant_transiciones-1:0] cand;
    logic [B-1:0]   auto_idx;
    logic           auto_hit;
    logic           has_q, take_cola;
    logic           intr_set;
    logic [1:0]     err_new, err_base;

    cola_disparos #(
        .DEPTH (tamano_cola),
        .WIDTH (B)
    ) u_cola (
        .clk   (Bus2IP_Clk),
        .rst   (Bus2IP_Reset),
        .push  (req_valid),
        .pop   (q_pop),
        .din   (req_trans),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign req_ready  = (q_count != Q_FULL);
    assign fire_start = fire_start_q;
    assign fire_trans = fire_trans_q;
    assign Interrupt  = intr_q;
    assign err_code   = err_q;
    assign busy       = (state_q != IDLE);

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        cand     = t_automatica & t_sensibilizadas;
        auto_hit = 1'b0;
        auto_idx = '0;
        for (int i = cant_transiciones - 1; i >= 0; i--) begin
            if (cand[i]) begin
                auto_hit = 1'b1;
                auto_idx = B'(i);
            end
        end
    end

    assign has_q     = !q_empty;
    assign take_cola = (has_q && auto_hit) ? (last_src_q == SRC_AUTO) : has_q;

    always_comb begin
        state_d      = state_q;
        last_src_d   = last_src_q;
        fire_trans_d = fire_trans_q;
        fire_start_d = 1'b0;
        cnt_d        = cnt_q;
        q_pop        = 1'b0;
        intr_set     = 1'b0;
        err_new      = ERR_NONE;
        unique case (state_q)
            IDLE: begin
                if (has_q || auto_hit) begin
                    state_d      = ISSUE;
                    fire_start_d = 1'b1;
                    q_pop        = take_cola;
                    last_src_d   = take_cola ? SRC_COLA : SRC_AUTO;
                    fire_trans_d = take_cola ? q_dout : auto_idx;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (fire_done) begin
                    state_d = IDLE;
                    if (fire_ok) begin
                        intr_set = t_intr[fire_trans_q];
                    end else begin
                        err_new = ERR_NO_SENS;
                    end
                end else if (cnt_d == TIMEOUT) begin
                    state_d = IDLE;
                    err_new = ERR_TIMEOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (err_new == ERR_NONE && req_valid && q_full) begin
            err_new = ERR_OVERFLOW;
        end
    end

    // A set in the same cycle as a clear takes precedence over the clear.
    assign err_base = err_clr ? ERR_NONE : err_q;
    assign err_d    = (err_base == ERR_NONE) ? err_new : err_base;
    assign intr_d   = intr_set || (intr_q && !intr_clr);

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q      <= IDLE;
            last_src_q   <= SRC_AUTO;
            fire_trans_q <= '0;
            fire_start_q <= 1'b0;
            cnt_q        <= '0;
            intr_q       <= 1'b0;
            err_q        <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            last_src_q   <= last_src_d;
            fire_trans_q <= fire_trans_d;
            fire_start_q <= fire_start_d;
            cnt_q        <= cnt_d;
            intr_q       <= intr_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_disparo_scheduler.sv
// Scenario bench for disparo_scheduler: behavioural engine responder plus
// a scoreboard of expected fire_trans values popped on every fire_start.
module tb_disparo_scheduler;

    localparam int N = 8;
    localparam int B = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [B-1:0] req_trans;
    logic         req_ready;
    logic [N-1:0] t_auto;
    logic [N-1:0] t_sens;
    logic [N-1:0] t_intr;
    logic         fire_start;
    logic [B-1:0] fire_trans;
    logic         fire_done;
    logic         fire_ok;
    logic         intr;
    logic         intr_clr;
    logic [1:0]   err_code;
    logic         err_clr;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_starts = 0;

    logic [B-1:0] sb[$];
    int           start_cyc[$];

    bit eng_en    = 1'b1;
    bit eng_ok    = 1'b1;
    int eng_delay = 1;

    disparo_scheduler #(
        .cant_transiciones      (N),
        .bits_cant_transiciones (B),
        .tamano_cola            (4),
        .timeout_ciclos         (255)
    ) dut (
        .Bus2IP_Clk       (clk),
        .Bus2IP_Reset     (rst),
        .req_valid        (req_valid),
        .req_trans        (req_trans),
        .req_ready        (req_ready),
        .t_automatica     (t_auto),
        .t_sensibilizadas (t_sens),
        .t_intr           (t_intr),
        .fire_start       (fire_start),
        .fire_trans       (fire_trans),
        .fire_done        (fire_done),
        .fire_ok          (fire_ok),
        .Interrupt        (intr),
        .intr_clr         (intr_clr),
        .err_code         (err_code),
        .err_clr          (err_clr),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every fire_start must match the oldest expected index.
    initial begin
        logic [B-1:0] exp_t;
        forever begin
            @(negedge clk);
            if (fire_start) begin
                n_starts++;
                start_cyc.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_start got=%0d expected=none", fire_trans);
                end else begin
                    exp_t = sb.pop_front();
                    if (fire_trans !== exp_t) begin
                        failures++;
                        $display("FAIL sb_fire_trans got=%0d expected=%0d", fire_trans, exp_t);
                    end
                end
            end
        end
    end

    // Engine model: answers eng_delay cycles after seeing fire_start.
    initial begin
        fire_done = 1'b0;
        fire_ok   = 1'b0;
        forever begin
            @(negedge clk);
            if (fire_start && eng_en) begin
                repeat (eng_delay) @(negedge clk);
                fire_done = 1'b1;
                fire_ok   = eng_ok;
                @(negedge clk);
                fire_done = 1'b0;
                fire_ok   = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_trans = '0;
        t_auto    = '0;
        t_sens    = '0;
        t_intr    = '0;
        intr_clr  = 1'b0;
        err_clr   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        sb.delete();
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic push_req(input logic [B-1:0] t);
        req_valid = 1'b1;
        req_trans = t;
        sb.push_back(t);
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (fire_start !== 1'b0) begin
            failures++; $display("FAIL rst_fire_start got=%b expected=0", fire_start);
        end
        checks++;
        if (fire_trans !== 3'd0) begin
            failures++; $display("FAIL rst_fire_trans got=%0d expected=0", fire_trans);
        end
        checks++;
        if (intr !== 1'b0) begin
            failures++; $display("FAIL rst_interrupt got=%b expected=0", intr);
        end
        checks++;
        if (err_code !== 2'b00) begin
            failures++; $display("FAIL rst_err got=%b expected=00", err_code);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL rst_busy got=%b expected=0", busy);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL rst_req_ready got=%b expected=1", req_ready);
        end
    endtask

    task automatic test_single();
        int push_cyc;
        int n0;
        bit ok;
        bit seen;
        t_intr    = 8'h04;
        eng_en    = 1'b1;
        eng_ok    = 1'b1;
        eng_delay = 1;
        n0        = n_starts;
        push_cyc  = cyc;
        push_req(3'd2);
        wait_idle(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL single_done got=busy expected=idle");
        end
        checks++;
        if (n_starts != n0 + 1) begin
            failures++; $display("FAIL single_starts got=%0d expected=%0d", n_starts - n0, 1);
        end
        checks++;
        if (start_cyc[$] - push_cyc != 2) begin
            failures++; $display("FAIL single_latency got=%0d expected=2", start_cyc[$] - push_cyc);
        end
        checks++;
        if (intr !== 1'b1) begin
            failures++; $display("FAIL single_interrupt got=%b expected=1", intr);
        end
        checks++;
        if (err_code !== 2'b00) begin
            failures++; $display("FAIL single_err got=%b expected=00", err_code);
        end
        intr_clr = 1'b1;
        step();
        intr_clr = 1'b0;
        checks++;
        if (intr !== 1'b0) begin
            failures++; $display("FAIL single_intr_clr got=%b expected=0", intr);
        end
        // intr_clr coinciding with the completing fire_done
        push_req(3'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fire_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        intr_clr = 1'b1;
        step();
        intr_clr = 1'b0;
        checks++;
        if (!seen || intr !== 1'b1) begin
            failures++; $display("FAIL intr_set_wins got=%b expected=1", intr);
        end
        wait_idle(20, ok);
        intr_clr = 1'b1;
        step();
        intr_clr = 1'b0;
        push_req(3'd3);
        wait_idle(20, ok);
        checks++;
        if (!ok || intr !== 1'b0) begin
            failures++; $display("FAIL intr_masked got=%b expected=0", intr);
        end
    endtask

    task automatic test_not_sens();
        bit ok;
        t_intr = 8'hFF;
        eng_en = 1'b1;
        eng_ok = 1'b0;
        push_req(3'd5);
        wait_idle(20, ok);
        checks++;
        if (!ok || intr !== 1'b0) begin
            failures++; $display("FAIL nosens_interrupt got=%b expected=0", intr);
        end
        checks++;
        if (err_code !== 2'b01) begin
            failures++; $display("FAIL nosens_err got=%b expected=01", err_code);
        end
        eng_en = 1'b0;
        push_req(3'd6);
        wait_idle(400, ok);
        checks++;
        if (!ok || err_code !== 2'b01) begin
            failures++; $display("FAIL nosens_sticky got=%b expected=01", err_code);
        end
        eng_en = 1'b1;
        eng_ok = 1'b1;
    endtask

    task automatic test_overflow();
        bit ok;
        eng_en = 1'b0;
        eng_ok = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    failures++; $display("FAIL ovf_ready_full got=%b expected=0", req_ready);
                end
            end else begin
                sb.push_back(B'(k));
            end
            req_valid = 1'b1;
            req_trans = B'(k);
            step();
        end
        req_valid = 1'b0;
        checks++;
        if (err_code !== 2'b10) begin
            failures++; $display("FAIL ovf_err got=%b expected=10", err_code);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err_code !== 2'b00) begin
            failures++; $display("FAIL ovf_err_clr got=%b expected=00", err_code);
        end
        eng_en = 1'b1;
        wait_idle(600, ok);
        checks++;
        if (!ok || err_code !== 2'b11) begin
            failures++; $display("FAIL ovf_drain_err got=%b expected=11", err_code);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL ovf_drain_ready got=%b expected=1", req_ready);
        end
    endtask

    task automatic test_arbitration();
        int n0;
        bit ok;
        bit reached;
        eng_en    = 1'b1;
        eng_ok    = 1'b1;
        eng_delay = 1;
        n0        = n_starts;
        req_valid = 1'b1;
        req_trans = 3'd1;
        sb.push_back(3'd1);
        step();
        req_trans = 3'd3;
        step();
        req_valid = 1'b0;
        t_auto    = 8'h80;
        t_sens    = 8'hFF;
        sb.push_back(3'd7);
        sb.push_back(3'd3);
        sb.push_back(3'd7);
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (n_starts == n0 + 4) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        t_auto = '0;
        t_sens = '0;
        wait_idle(20, ok);
        checks++;
        if (!reached || !ok || n_starts != n0 + 4) begin
            failures++; $display("FAIL arb_count got=%0d expected=4", n_starts - n0);
        end
    endtask

    task automatic test_timeout();
        int n0;
        int s;
        int idle_cyc;
        bit ok;
        eng_en = 1'b0;
        n0     = n_starts;
        push_req(3'd0);
        push_req(3'd4);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (n_starts == n0 + 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        s        = start_cyc[n0];
        idle_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            step();
        end
        checks++;
        if (!ok || idle_cyc - s != 256) begin
            failures++; $display("FAIL tmo_wait_len got=%0d expected=256", idle_cyc - s);
        end
        checks++;
        if (err_code !== 2'b11) begin
            failures++; $display("FAIL tmo_err got=%b expected=11", err_code);
        end
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (n_starts == n0 + 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok || start_cyc[$] - s != 257) begin
            failures++; $display("FAIL tmo_next_issue got=%0d expected=257", start_cyc[$] - s);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        bit ok;
        t_intr    = 8'hFF;
        eng_en    = 1'b1;
        eng_ok    = 1'b1;
        eng_delay = 6;
        n0        = n_starts;
        req_valid = 1'b1;
        req_trans = 3'd0;
        sb.push_back(3'd0);
        step();
        req_trans = 3'd1;
        step();
        req_trans = 3'd2;
        step();
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (n_starts == n0 + 1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (!ok || busy !== 1'b0) begin
            failures++; $display("FAIL rmid_busy got=%b expected=0", busy);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL rmid_ready got=%b expected=1", req_ready);
        end
        repeat (12) step();
        checks++;
        if (n_starts != n0 + 1) begin
            failures++; $display("FAIL rmid_flush got=%0d expected=1", n_starts - n0);
        end
        checks++;
        if (intr !== 1'b0 || err_code !== 2'b00) begin
            failures++; $display("FAIL rmid_late_done got=%b/%b expected=0/00", intr, err_code);
        end
        eng_delay = 1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_trans = '0;
        t_auto    = '0;
        t_sens    = '0;
        t_intr    = '0;
        intr_clr  = 1'b0;
        err_clr   = 1'b0;
        apply_reset();
        test_reset();
        test_single();
        apply_reset();
        test_not_sens();
        apply_reset();
        test_overflow();
        apply_reset();
        test_arbitration();
        apply_reset();
        test_timeout();
        apply_reset();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_leftover got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
